// File: rtl/gon_collector.sv
// Gathers psum words from tag-matched PEs (lowest index first) onto one valid/ready port.
// One-cycle accept-to-output latency; no PE is granted while the output register is stalled.
module gon_collector #(
  parameter int NUMS_PE_ROW = 6,
  parameter int NUMS_PE_COL = 8,
  parameter int DATA_BITS   = 32,
  parameter int XID_BITS    = 5,
  parameter int YID_BITS    = 3,
  parameter int LEN_BITS    = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       set_XID,
  input  logic [XID_BITS-1:0]                        XID_scan_in,
  input  logic                                       set_YID,
  input  logic [YID_BITS-1:0]                        YID_scan_in,
  input  logic                                       start,
  input  logic [LEN_BITS-1:0]                        len,
  input  logic [XID_BITS-1:0]                        tag_X,
  input  logic [YID_BITS-1:0]                        tag_Y,
  output logic                                       busy,
  output logic                                       done,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           PE_valid,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           PE_ready,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL*DATA_BITS-1:0] PE_data,
  output logic                                       GON_valid,
  input  logic                                       GON_ready,
  output logic [DATA_BITS-1:0]                       GON_data,
  output logic [5:0]                                 GON_src
);
  localparam int NPE = NUMS_PE_ROW * NUMS_PE_COL;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [XID_BITS-1:0]   xid_q [NPE];
  logic [YID_BITS-1:0]   yid_q [NUMS_PE_ROW];
  logic [LEN_BITS-1:0]   len_q, len_d, cnt_q, cnt_d;
  logic [XID_BITS-1:0]   tagx_q, tagx_d;
  logic [YID_BITS-1:0]   tagy_q, tagy_d;
  logic                  gvld_q, gvld_d;
  logic [DATA_BITS-1:0]  gdat_q, gdat_d;
  logic [5:0]            gsrc_q, gsrc_d;

  logic [NPE-1:0]        elig;
  logic                  any_elig, grant_en, drain;
  logic [5:0]            grant_idx;

  // Scan chains shift only while idle so IDs cannot change under a live transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NPE; k++) xid_q[k] <= '1;
      for (int r = 0; r < NUMS_PE_ROW; r++) yid_q[r] <= '1;
    end else if (state_q == S_IDLE) begin
      if (set_XID) begin
        xid_q[0] <= XID_scan_in;
        for (int k = 1; k < NPE; k++) xid_q[k] <= xid_q[k-1];
      end
      if (set_YID) begin
        yid_q[0] <= YID_scan_in;
        for (int r = 1; r < NUMS_PE_ROW; r++) yid_q[r] <= yid_q[r-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      tagx_q  <= '0;
      tagy_q  <= '0;
      gvld_q  <= 1'b0;
      gdat_q  <= '0;
      gsrc_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tagx_q  <= tagx_d;
      tagy_q  <= tagy_d;
      gvld_q  <= gvld_d;
      gdat_q  <= gdat_d;
      gsrc_q  <= gsrc_d;
    end
  end

  always_comb begin
    elig      = '0;
    any_elig  = 1'b0;
    grant_idx = '0;
    for (int k = NPE - 1; k >= 0; k--) begin
      elig[k] = PE_valid[k] && (xid_q[k] == tagx_q) && (yid_q[k / NUMS_PE_COL] == tagy_q);
      if (elig[k]) begin
        any_elig  = 1'b1;
        grant_idx = 6'(k);
      end
    end
  end

  // A ready is only ever raised on an eligible (hence valid) PE, so a grant is an accept.
  assign grant_en = (state_q == S_BUSY) && (!gvld_q || GON_ready) && (cnt_q < len_q) && any_elig;
  assign drain    = gvld_q && GON_ready;

  always_comb begin
    PE_ready = '0;
    if (grant_en) PE_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tagx_d  = tagx_q;
    tagy_d  = tagy_q;
    gvld_d  = gvld_q;
    gdat_d  = gdat_q;
    gsrc_d  = gsrc_q;

    if (grant_en) begin
      gvld_d = 1'b1;
      gdat_d = PE_data[int'(grant_idx)*DATA_BITS +: DATA_BITS];
      gsrc_d = grant_idx;
      cnt_d  = cnt_q + LEN_BITS'(1);
    end else if (drain) begin
      gvld_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: if (start) begin
        len_d   = len;
        tagx_d  = tag_X;
        tagy_d  = tag_Y;
        cnt_d   = '0;
        state_d = (len == '0) ? S_DONE : S_BUSY;
      end
      // A word draining this same cycle counts as an empty buffer.
      S_BUSY:  if (cnt_q == len_q) state_d = (gvld_q && !GON_ready) ? S_DRAIN : S_DONE;
      S_DRAIN: if (drain) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign GON_valid = gvld_q;
  assign GON_data  = gdat_q;
  assign GON_src   = gsrc_q;
endmodule
